// File: rtl/qs_srt_bank_scheduler.sv
// -----------------------------------------------------------------------------
// qs_srt_bank_scheduler
//   Hands memory banks to the sort engine. The engine stalls on `await`
//   until a filled bank is granted, then signals `done` once the bank is
//   sorted. Each bank cycles EMPTY -> READY -> SORTING -> SORTED -> EMPTY.
//   Banks are granted in round-robin order, starting from the bank after
//   the most recently sorted one.
//
// Ports
//   clk, arst_n    clock, asynchronous active-low reset
//   fill_done_i    per-bank pulse: ingress has filled bank i
//   release_i      per-bank pulse: egress has drained sorted bank i
//   await_req_i    level: engine is stalled on `await`
//   done_i         pulse: engine finished sorting the selected bank
//   await_ack_o    pulse: bank_sel_o now belongs to the engine
//   bank_sel_o     selected bank index
//   busy_o         engine owns a bank
//   sorted_o       per-bank pulse: bank i has just been sorted
//   bank_ready_o   per-bank status: bank i is filled and waiting
//   err_o          sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------

// Lifecycle of a single bank. Illegal fill/release events are reported
// and otherwise ignored.
module qs_srt_bank_slot (
    input  logic clk,
    input  logic arst_n,
    input  logic fill,
    input  logic rel,
    input  logic grant,
    input  logic sort_done,
    output logic ready_q,
    output logic err
);
    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_READY   = 2'd1,
        B_SORTING = 2'd2,
        B_SORTED  = 2'd3
    } bank_st_e;

    bank_st_e st_q, st_d;

    always_comb begin
        st_d = st_q;
        err  = 1'b0;
        // A fill colliding with a release on a SORTED bank fails this
        // check (bank not EMPTY at cycle start) while the release wins.
        if (fill) begin
            if (st_q == B_EMPTY) st_d = B_READY;
            else                 err  = 1'b1;
        end
        if (rel) begin
            if (st_q == B_SORTED) st_d = B_EMPTY;
            else                  err  = 1'b1;
        end
        // The controller only grants READY banks and only completes the
        // SORTING bank, so these never overlap a legal fill or release.
        if (grant)     st_d = B_SORTING;
        if (sort_done) st_d = B_SORTED;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st_q    <= B_EMPTY;
            ready_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            ready_q <= (st_d == B_READY);
        end
    end
endmodule

module qs_srt_bank_scheduler #(
    parameter  int BANKS_N = 4,
    localparam int BANK_W  = $clog2(BANKS_N)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [BANKS_N-1:0] fill_done_i,
    input  logic [BANKS_N-1:0] release_i,
    input  logic               await_req_i,
    input  logic               done_i,
    output logic               await_ack_o,
    output logic [BANK_W-1:0]  bank_sel_o,
    output logic               busy_o,
    output logic [BANKS_N-1:0] sorted_o,
    output logic [BANKS_N-1:0] bank_ready_o,
    output logic               err_o
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } ctl_st_e;

    ctl_st_e             state_q;
    logic [BANK_W-1:0]   rr_ptr_q;
    logic                await_q;
    logic [BANKS_N-1:0]  grant_vec;
    logic [BANKS_N-1:0]  sort_vec;
    logic [BANKS_N-1:0]  bank_err;
    logic                pick_vld;
    logic [BANK_W-1:0]   pick_idx;
    logic                do_grant;
    logic                do_done;
    logic                ctl_err;

    // First READY bank at or above the rr pointer, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < BANKS_N; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= BANKS_N) j = j - BANKS_N;
            if (!pick_vld && bank_ready_o[j]) begin
                pick_vld = 1'b1;
                pick_idx = BANK_W'(j);
            end
        end
    end

    assign do_grant = (state_q == S_IDLE) && await_req_i && pick_vld;
    assign do_done  = (state_q == S_BUSY) && done_i;

    // A request raised together with done is legal: done retires the bank
    // first and the request is then served from IDLE.
    assign ctl_err = (done_i && state_q == S_IDLE) ||
                     (await_req_i && !await_q && state_q == S_BUSY && !done_i);

    for (genvar i = 0; i < BANKS_N; i++) begin : g_bank
        assign grant_vec[i] = do_grant && (pick_idx == BANK_W'(i));
        assign sort_vec[i]  = do_done && (bank_sel_o == BANK_W'(i));

        qs_srt_bank_slot u_slot (
            .clk       (clk),
            .arst_n    (arst_n),
            .fill      (fill_done_i[i]),
            .rel       (release_i[i]),
            .grant     (grant_vec[i]),
            .sort_done (sort_vec[i]),
            .ready_q   (bank_ready_o[i]),
            .err       (bank_err[i])
        );
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            await_q     <= 1'b0;
            await_ack_o <= 1'b0;
            bank_sel_o  <= '0;
            busy_o      <= 1'b0;
            sorted_o    <= '0;
            err_o       <= 1'b0;
        end else begin
            await_q     <= await_req_i;
            await_ack_o <= 1'b0;
            sorted_o    <= '0;
            err_o       <= err_o | ctl_err | (|bank_err);
            case (state_q)
                S_IDLE: begin
                    if (do_grant) begin
                        state_q     <= S_BUSY;
                        bank_sel_o  <= pick_idx;
                        await_ack_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (do_done) begin
                        state_q  <= S_IDLE;
                        busy_o   <= 1'b0;
                        sorted_o <= sort_vec;
                        rr_ptr_q <= (bank_sel_o == BANK_W'(BANKS_N - 1)) ?
                                    '0 : bank_sel_o + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/qs_srt_bank_scheduler.md
Name: qs_srt_bank_scheduler

Overview:
- Schedules the sort engine's microcode `await`/`done` instructions against a set of independently filled memory banks.
- Tracks each bank's lifecycle: empty, filled, being sorted, sorted.
- On `await`, grants the next filled bank to the engine in round-robin order. On `done`, retires the current bank to the egress side.
- Sits between the bank ingress/egress logic and the engine's instruction sequencer, which stalls on `await` until acknowledged.

Parameters:
- BANKS_N, 4, number of banks; must be at least 2.
- BANK_W, $clog2(BANKS_N), bank index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset; asynchronous, active-low.
- fill_done_i  in  BANKS_N  one-cycle pulse per bank: ingress has completely filled bank i.
- release_i  in  BANKS_N  one-cycle pulse per bank: egress has drained sorted bank i.
- await_req_i  in  1  level; engine is stalled on `await`. Held until await_ack_o is seen.
- done_i  in  1  one-cycle pulse; engine executed `done` on the selected bank.
- await_ack_o  out  1  one-cycle pulse; the bank on bank_sel_o is now owned by the engine.
- bank_sel_o  out  BANK_W  currently selected bank index.
- busy_o  out  1  engine owns a bank.
- sorted_o  out  BANKS_N  one-cycle pulse per bank: bank i has been sorted.
- bank_ready_o  out  BANKS_N  status; bank i is filled and waiting.
- err_o  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Per-bank state (2 bits each): EMPTY, READY, SORTING, SORTED. All outputs are registered.
- Reset values:
  - All banks EMPTY; controller in IDLE; rr pointer 0.
  - bank_sel_o=0; await_ack_o, busy_o, sorted_o, bank_ready_o and err_o all 0.
- Bank transitions:
  - EMPTY→READY on fill_done_i[i].
  - READY→SORTING on grant.
  - SORTING→SORTED on done_i.
  - SORTED→EMPTY on release_i[i].
  - Every input event is evaluated against the state at the start of the cycle. The new state is visible at the next cycle.
- Controller FSM, IDLE and BUSY:
  - IDLE, cycle N, with await_req_i=1 and at least one READY bank: select the first READY bank searching upward from the rr pointer, wrapping modulo BANKS_N. At cycle N+1: await_ack_o=1 for one cycle, bank_sel_o=index, busy_o=1, FSM=BUSY. Grant latency is 1 cycle.
  - IDLE with await_req_i=1 and no READY bank: wait, no ack. A bank filled at cycle N is first eligible at N+1, so the earliest ack is at N+2.
  - BUSY, done_i at cycle N: at N+1, sorted_o[bank_sel_o]=1 for one cycle, bank=SORTED, busy_o=0, FSM=IDLE, rr pointer=(bank_sel_o+1) mod BANKS_N. bank_sel_o holds its last value.
  - done_i and await_req_i in the same cycle while BUSY: done_i is processed first. The await is served from IDLE, with ack at N+2 at the earliest.
  - await_req_i held high in the cycle await_ack_o is asserted is not a new request. A new request is recognised only from IDLE.
- Errors: each sets err_o at N+1 and the offending event is ignored; state is otherwise unchanged.
  - fill_done_i[i] with bank i not EMPTY.
  - release_i[i] with bank i not SORTED.
  - done_i while IDLE.
  - await_req_i rising while BUSY.
- Simultaneous events:
  - fill_done_i and release_i on the same bank in one cycle: release is applied, fill is flagged as an error.
  - Events on different banks in the same cycle are independent and all applied.
- Reset asserted mid-operation: all state returns to the reset values immediately. Any in-flight grant or done is lost and no sorted_o pulse is emitted.

Test Plan:
- Reset, fill_done_i=0001 at cycle 2, await_req_i=1 from cycle 3 → await_ack_o=1 at cycle 4, bank_sel_o=0, busy_o=1, bank_ready_o=0000 at cycle 5.
- Banks 0–3 all READY, four await/done rounds → grants in order 0,1,2,3. sorted_o pulses 0001, 0010, 0100, 1000, each one cycle after the corresponding done_i.
- rr pointer=2, READY banks {0,1} → grant bank 0 (wrap-around). Release bank 0 after its done → state EMPTY. A second release on bank 0 → err_o=1.
- await_req_i=1 with all banks EMPTY for 10 cycles → no ack. fill_done_i[3] at cycle 10 → ack at cycle 12 with bank_sel_o=3.
- done_i while IDLE; fill_done_i on a READY bank; await_req_i rising while BUSY → each sets err_o and leaves bank states unchanged. err_o stays 1 until reset.
- arst_n deasserted-low while BUSY on bank 1 → busy_o=0, bank_sel_o=0, all bank_ready_o=0 immediately. No sorted_o pulse after reset is released.
